cpu_seq_ctrl: RTL and testbench
===============================

Name: cpu_seq_ctrl

Overview:
- Multi-cycle control sequencer for the 32-bit datapath: 6-bit PC, register file with 6-bit addresses, ALU with 4-bit opsel, immediate mux.
- Owns the PC and fetches from instruction memory over a req/ack handshake.
- Decodes each instruction and drives ALUopsel, MUXsel, RegWrite and the register addresses through FETCH/DECODE/EXEC/WB.
- Samples the ALU flags to resolve branches and overflow traps.

Parameters:
RESET_PC, 6'd0, PC value loaded on reset
FETCH_TIMEOUT, 15, maximum cycles waiting for imem_ack before ERR
TRAP_OVF, 1, 1 = overflow on ADD/ADDI/SUB suppresses write and enters ERR
ADD_OP, 4'h0, ALUopsel code used for ADDI
SUB_OP, 4'h1, ALUopsel code used for BEQ compare

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
enable  in  1  run permission; sampled in IDLE and at end of WB
imem_req  out  1  fetch request
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  32  instruction word
pc_out  out  6  current PC, also the fetch address
instr  out  32  latched instruction register (IR)
rs  out  6  source A address
rt  out  6  source B address
rd  out  6  write address
imm  out  16  immediate field
ALUopsel  out  4  ALU operation
MUXsel  out  1  0 = operandB from RD2, 1 = ext_imm
RegWrite  out  1  register file write strobe
equal  in  1  ALU equal flag
carry  in  1  ALU carry flag (not used for control; kept for future use)
overflow  in  1  ALU overflow flag
halted  out  1  HALT reached
error  out  1  ERR state (illegal opcode, fetch timeout, overflow trap)

Behaviour:
- Reset (rst=0, async): state=IDLE, pc_out=RESET_PC, instr=0, imem_req=0, RegWrite=0, MUXsel=0, ALUopsel=0, halted=0, error=0. RegWrite drops immediately, even mid-WB.
- IR fields: opcode=IR[31:28], rs=IR[27:22], rt=IR[21:16], rd=IR[15:10], imm=IR[15:0], func=IR[3:0]. rs/rt/rd/imm are combinational from IR.
- Opcodes:
  - 0x0 R-type: ALUopsel=func, MUXsel=0, writes rd.
  - 0x1 ADDI: ALUopsel=ADD_OP, MUXsel=1, writes rt.
  - 0x2 BEQ: ALUopsel=SUB_OP, MUXsel=0, no write.
  - 0xE HALT.
  - 0xF NOP.
  - Any other opcode -> ERR.
- IDLE: if enable=1 -> FETCH, else stay.
- FETCH: imem_req=1 and pc_out held stable.
  - On imem_ack=1: IR<=imem_rdata -> DECODE.
  - Wait counter reaching FETCH_TIMEOUT cycles without ack -> ERR, imem_req=0.
- DECODE (1 cycle): ALUopsel/MUXsel drive the decoded values. HALT -> HALT state. Illegal opcode -> ERR.
- EXEC (1 cycle): controls held. Flags sampled at the clock edge ending EXEC.
- WB (1 cycle), controls held:
  - RegWrite=1 for R-type/ADDI only when dest!=0 and no trapped overflow. Writes to r0 are suppressed.
  - Trapped overflow (TRAP_OVF=1): RegWrite=0, PC not advanced -> ERR.
  - PC update: BEQ with equal=1 -> pc+1+imm[5:0]; otherwise pc+1. All PC arithmetic is 6-bit modulo 64 (63+1=0).
  - Next state: enable=1 -> FETCH, else IDLE.
- Minimum latency: 4 cycles per instruction when ack arrives in the first FETCH cycle.
- enable deassert mid-instruction: the current instruction completes, then IDLE.
- HALT: halted=1, imem_req=0. Stays until reset.
- ERR: error=1, RegWrite=0, imem_req=0. Stays until reset.
- imem_ack outside FETCH is ignored.

Test Plan:
- Reset then enable=1, imem returns ADDI rt=5 imm=7 with ack in the first cycle -> imem_req high 1 cycle; MUXsel=1, ALUopsel=0 during DECODE–WB; RegWrite=1 in cycle 4 only; pc_out 0->1.
- R-type rs=1 rt=2 rd=3 func=4'h6, ack delayed 3 cycles -> pc_out held and imem_req high for 4 cycles; ALUopsel=6; RegWrite on rd=3; 7 cycles total. Same instruction with rd=0 -> RegWrite never asserts.
- BEQ imm=16'hFFFE at pc=10: equal=1 -> pc=9; equal=0 -> pc=11. BEQ at pc=63 with equal=0 -> pc=0 (wrap).
- Opcode 0x7 -> error=1 after DECODE and no further imem_req. Withholding ack for 15 cycles -> error=1. ADD with overflow=1 -> no RegWrite, error=1, pc unchanged.
- HALT -> halted=1, pc frozen. Drop enable during EXEC -> WB completes, then IDLE. Assert rst during WB -> RegWrite=0 immediately, pc=RESET_PC.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle control sequencer for the 32-bit datapath.
// It owns the 6-bit PC, fetches instructions over a req/ack handshake,
// and decodes each one. It then drives the ALU, operand mux and
// register-file controls through FETCH / DECODE / EXEC / WB.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   enable          run permission, sampled in IDLE and at the end of WB
//   imem_req/ack    fetch handshake; imem_rdata is the fetched word
//   pc_out          current PC and fetch address
//   instr           instruction register; rs/rt/rd/imm are fields of it
//   ALUopsel        ALU operation
//   MUXsel          operand B select (0 = RD2, 1 = immediate)
//   RegWrite        register file write strobe (asserted in WB only)
//   equal/overflow  ALU flags, sampled on the edge that ends EXEC
//   carry           ALU carry flag, not used for control
//   halted/error    sticky terminal states, cleared only by reset
module cpu_seq_ctrl #(
  parameter logic [5:0] RESET_PC      = 6'd0,
  parameter int         FETCH_TIMEOUT = 15,
  parameter bit         TRAP_OVF      = 1'b1,
  parameter logic [3:0] ADD_OP        = 4'h0,
  parameter logic [3:0] SUB_OP        = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [5:0]  pc_out,
  output logic [31:0] instr,
  output logic [5:0]  rs,
  output logic [5:0]  rt,
  output logic [5:0]  rd,
  output logic [15:0] imm,
  output logic [3:0]  ALUopsel,
  output logic        MUXsel,
  output logic        RegWrite,
  input  logic        equal,
  input  logic        carry,
  input  logic        overflow,
  output logic        halted,
  output logic        error
);

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_BEQ   = 4'h2;
  localparam logic [3:0] OP_HALT  = 4'hE;
  localparam logic [3:0] OP_NOP   = 4'hF;

  localparam int              CNT_W    = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_ERR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             equal_wb;
  logic             trap_wb;

  logic [3:0] opcode;
  logic [3:0] func;
  logic [5:0] dest;
  logic       wr_op;
  logic       ovf_op;
  logic       trap_now;
  logic       unused_carry;

  assign opcode = instr[31:28];
  assign rs     = instr[27:22];
  assign rt     = instr[21:16];
  assign rd     = instr[15:10];
  assign imm    = instr[15:0];
  assign func   = instr[3:0];

  assign dest     = (opcode == OP_RTYPE) ? rd : rt;
  assign wr_op    = (opcode == OP_RTYPE) || (opcode == OP_ADDI);
  assign ovf_op   = (opcode == OP_ADDI) ||
                    ((opcode == OP_RTYPE) && ((func == ADD_OP) || (func == SUB_OP)));
  assign trap_now = TRAP_OVF && ovf_op && overflow;

  assign unused_carry = carry;

  // Returns {MUXsel, ALUopsel} for a fetched word; non-ALU opcodes give zero.
  function automatic logic [4:0] decode_ctrl(input logic [31:0] word);
    case (word[31:28])
      OP_RTYPE: return {1'b0, word[3:0]};
      OP_ADDI:  return {1'b1, ADD_OP};
      OP_BEQ:   return {1'b0, SUB_OP};
      default:  return 5'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      pc_out   <= RESET_PC;
      instr    <= '0;
      imem_req <= 1'b0;
      RegWrite <= 1'b0;
      MUXsel   <= 1'b0;
      ALUopsel <= '0;
      halted   <= 1'b0;
      error    <= 1'b0;
      wait_cnt <= '0;
      equal_wb <= 1'b0;
      trap_wb  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
            wait_cnt <= '0;
          end
        end

        // FETCH -> DECODE: IR and the ALU/mux controls load together on ack
        S_FETCH: begin
          if (imem_ack) begin
            instr               <= imem_rdata;
            {MUXsel, ALUopsel}  <= decode_ctrl(imem_rdata);
            imem_req            <= 1'b0;
            state               <= S_DECODE;
          end else if (wait_cnt == CNT_LAST) begin
            imem_req <= 1'b0;
            error    <= 1'b1;
            state    <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        // DECODE -> EXEC / HALT / ERR
        S_DECODE: begin
          case (opcode)
            OP_RTYPE, OP_ADDI, OP_BEQ, OP_NOP: state <= S_EXEC;
            OP_HALT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              error <= 1'b1;
              state <= S_ERR;
            end
          endcase
        end

        // EXEC -> WB: ALU flags captured here; the write strobe is decided now
        S_EXEC: begin
          equal_wb <= equal;
          trap_wb  <= trap_now;
          RegWrite <= wr_op && (dest != 6'd0) && !trap_now;
          state    <= S_WB;
        end

        // WB -> FETCH / IDLE / ERR: PC advances only when no trap occurred
        S_WB: begin
          RegWrite <= 1'b0;
          if (trap_wb) begin
            error <= 1'b1;
            state <= S_ERR;
          end else begin
            if ((opcode == OP_BEQ) && equal_wb)
              pc_out <= pc_out + 6'd1 + instr[5:0];
            else
              pc_out <= pc_out + 6'd1;
            if (enable) begin
              state    <= S_FETCH;
              imem_req <= 1'b1;
              wait_cnt <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        S_HALT: begin
          imem_req <= 1'b0;
          RegWrite <= 1'b0;
        end

        S_ERR: begin
          imem_req <= 1'b0;
          RegWrite <= 1'b0;
        end

        default: begin
          imem_req <= 1'b0;
          RegWrite <= 1'b0;
          error    <= 1'b1;
          state    <= S_ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed testbench for cpu_seq_ctrl: hand-computed expectations checked
// with immediate assertions, one linear stimulus sequence.
module tb_cpu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [5:0]  pc_out;
  logic [31:0] instr;
  logic [5:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [3:0]  ALUopsel;
  logic        MUXsel;
  logic        RegWrite;
  logic        equal, carry, overflow;
  logic        halted, error;

  int n_cmp = 0;
  int n_bad = 0;

  // values captured by run_instr
  logic [3:0]  o_alu;
  logic        o_mux;
  logic [5:0]  o_rs, o_rt, o_rd;
  logic [15:0] o_imm;
  logic        o_rw_exec, o_rw_wb;
  int          o_req_cnt;
  logic        o_pc_moved;

  cpu_seq_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .instr(instr), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .ALUopsel(ALUopsel), .MUXsel(MUXsel), .RegWrite(RegWrite),
    .equal(equal), .carry(carry), .overflow(overflow),
    .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts in FETCH cycle 1; ends in the cycle after WB.
  task automatic run_instr(input logic [31:0] word, input int dly,
                           input logic eq, input logic ov, input logic en);
    logic [5:0] pc0;
    pc0        = pc_out;
    o_req_cnt  = 0;
    o_pc_moved = 1'b0;
    imem_ack   = 1'b0;
    for (int i = 0; i < dly; i++) begin
      if (imem_req === 1'b1) o_req_cnt++;
      if (pc_out !== pc0) o_pc_moved = 1'b1;
      step();
    end
    if (imem_req === 1'b1) o_req_cnt++;
    if (pc_out !== pc0) o_pc_moved = 1'b1;
    imem_rdata = word;
    imem_ack   = 1'b1;
    step();
    imem_ack = 1'b0;
    o_alu = ALUopsel; o_mux = MUXsel;
    o_rs = rs; o_rt = rt; o_rd = rd; o_imm = imm;
    step();
    o_rw_exec = RegWrite;
    equal = eq; overflow = ov; enable = en;
    step();
    o_rw_wb = RegWrite;
    equal = 1'b0; overflow = 1'b0;
    step();
  endtask

  task automatic rst_to_fetch();
    rst = 1'b0; enable = 1'b0; imem_ack = 1'b0; equal = 1'b0; overflow = 1'b0;
    step();
    rst = 1'b1; enable = 1'b1;
    step();
  endtask

  localparam logic [31:0] I_ADDI = {4'h1, 6'd0, 6'd5, 16'd7};
  localparam logic [31:0] I_R3   = {4'h0, 6'd1, 6'd2, 6'd3, 6'd0, 4'h6};
  localparam logic [31:0] I_R0   = {4'h0, 6'd1, 6'd2, 6'd0, 6'd0, 4'h6};
  localparam logic [31:0] I_ADD4 = {4'h0, 6'd1, 6'd2, 6'd4, 6'd0, 4'h0};
  localparam logic [31:0] I_B6   = {4'h2, 12'd0, 16'd6};
  localparam logic [31:0] I_BM2  = {4'h2, 12'd0, 16'hFFFE};
  localparam logic [31:0] I_B51  = {4'h2, 12'd0, 16'd51};
  localparam logic [31:0] I_NOP  = {4'hF, 28'd0};
  localparam logic [31:0] I_HALT = {4'hE, 28'd0};
  localparam logic [31:0] I_ILL  = {4'h7, 28'd0};

  initial begin
    rst = 1'b1; enable = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    equal = 1'b0; carry = 1'b0; overflow = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_pc", pc_out, 0);
    check("rst_instr", instr, 0);
    check("rst_req", imem_req, 0);
    check("rst_rw", RegWrite, 0);
    check("rst_mux", MUXsel, 0);
    check("rst_alu", ALUopsel, 0);
    check("rst_halted", halted, 0);
    check("rst_error", error, 0);
    step();
    rst = 1'b1;
    step(); step();
    check("idle_no_req", imem_req, 0);
    enable = 1'b1;
    step();
    check("fetch_req", imem_req, 1);

    // ADDI rt=5 imm=7, ack on first cycle
    run_instr(I_ADDI, 0, 1'b0, 1'b0, 1'b1);
    check("addi_req_cycles", o_req_cnt, 1);
    check("addi_alu", o_alu, 0);
    check("addi_mux", o_mux, 1);
    check("addi_rt", o_rt, 5);
    check("addi_imm", o_imm, 7);
    check("addi_rw_exec", o_rw_exec, 0);
    check("addi_rw_wb", o_rw_wb, 1);
    check("addi_pc", pc_out, 1);
    check("addi_next_req", imem_req, 1);
    check("addi_rw_after", RegWrite, 0);

    // R-type rd=3 func=6, ack delayed 3 cycles
    run_instr(I_R3, 3, 1'b0, 1'b0, 1'b1);
    check("r3_req_cycles", o_req_cnt, 4);
    check("r3_pc_held", o_pc_moved, 0);
    check("r3_alu", o_alu, 6);
    check("r3_mux", o_mux, 0);
    check("r3_rs", o_rs, 1);
    check("r3_rd", o_rd, 3);
    check("r3_rw_wb", o_rw_wb, 1);
    check("r3_pc", pc_out, 2);

    // same with rd=0
    run_instr(I_R0, 0, 1'b0, 1'b0, 1'b1);
    check("r0_rw_exec", o_rw_exec, 0);
    check("r0_rw_wb", o_rw_wb, 0);
    check("r0_pc", pc_out, 3);

    // branches
    run_instr(I_B6, 0, 1'b1, 1'b0, 1'b1);
    check("beq6_alu", o_alu, 1);
    check("beq6_mux", o_mux, 0);
    check("beq6_rw", o_rw_wb, 0);
    check("beq6_pc", pc_out, 10);
    run_instr(I_BM2, 0, 1'b1, 1'b0, 1'b1);
    check("beqm2_taken_pc", pc_out, 9);
    run_instr(I_NOP, 0, 1'b0, 1'b0, 1'b1);
    check("nop_rw", o_rw_wb, 0);
    check("nop_pc", pc_out, 10);
    run_instr(I_BM2, 0, 1'b0, 1'b0, 1'b1);
    check("beqm2_nt_pc", pc_out, 11);
    run_instr(I_B51, 0, 1'b1, 1'b0, 1'b1);
    check("beq51_pc", pc_out, 63);
    run_instr(I_B6, 0, 1'b0, 1'b0, 1'b1);
    check("wrap_pc", pc_out, 0);

    // drop enable during EXEC: WB completes then IDLE
    run_instr(I_R3, 0, 1'b0, 1'b0, 1'b0);
    check("drop_rw_wb", o_rw_wb, 1);
    check("drop_pc", pc_out, 1);
    check("drop_req", imem_req, 0);
    step(); step();
    check("idle_req", imem_req, 0);
    check("idle_pc", pc_out, 1);
    enable = 1'b1;
    step();
    check("resume_req", imem_req, 1);

    // HALT
    imem_rdata = I_HALT; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check("halt_decode", halted, 0);
    step();
    check("halted", halted, 1);
    check("halt_req", imem_req, 0);
    imem_ack = 1'b1;
    step(); step(); step();
    imem_ack = 1'b0;
    check("halt_pc_frozen", pc_out, 1);
    check("halt_sticky", halted, 1);
    check("halt_req_stays", imem_req, 0);

    // illegal opcode
    rst_to_fetch();
    check("rst2_halted", halted, 0);
    check("rst2_pc", pc_out, 0);
    imem_rdata = I_ILL; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check("ill_decode_err", error, 0);
    step();
    check("ill_error", error, 1);
    check("ill_req", imem_req, 0);
    imem_ack = 1'b1;
    step(); step(); step();
    imem_ack = 1'b0;
    check("ill_req_stays", imem_req, 0);
    check("ill_err_sticky", error, 1);

    // fetch timeout
    rst_to_fetch();
    repeat (14) step();
    check("to_req_c15", imem_req, 1);
    check("to_err_c15", error, 0);
    step();
    check("to_error", error, 1);
    check("to_req", imem_req, 0);

    // overflow trap on ADD
    rst_to_fetch();
    run_instr(I_ADD4, 0, 1'b0, 1'b1, 1'b1);
    check("ovf_rw", o_rw_wb, 0);
    check("ovf_error", error, 1);
    check("ovf_pc", pc_out, 0);
    check("ovf_req", imem_req, 0);

    // reset during WB
    rst_to_fetch();
    run_instr(I_ADDI, 0, 1'b0, 1'b0, 1'b1);
    check("e_pc1", pc_out, 1);
    imem_rdata = I_ADDI; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step(); step();
    check("wb_rw_before", RegWrite, 1);
    #2 rst = 1'b0;
    #1;
    check("wb_rst_rw", RegWrite, 0);
    check("wb_rst_pc", pc_out, 0);
    check("wb_rst_instr", instr, 0);
    check("wb_rst_req", imem_req, 0);
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
